// File: rtl/execute_unit_if.sv
// Issue-side and result-side bus of the integer execute stage, bundled for master (issue/LSQ/ROB/CDB side) and slave (execute_unit).
// ctrl_in layout: [8:5] aluop, [4] memtoreg, [3] memwr, [2] cjump, [1] ucjump, [0] regwrite.
interface execute_unit_if #(
    parameter int WIDTH = 32,
    parameter int ROB_W = 5,
    parameter int RS_W  = 4,
    parameter int LSQ_W = 4
);
    logic             flush;
    logic [ROB_W-1:0] tag_in;
    logic [RS_W-1:0]  rs_id_in;
    logic [LSQ_W-1:0] lsq_id_in;
    logic [WIDTH-1:0] source_a;
    logic [WIDTH-1:0] source_b;
    logic [WIDTH-1:0] data_in;
    logic [8:0]       ctrl_in;
    logic             exe_busy;
    logic             cdb_valid;
    logic             cdb_ready;
    logic [ROB_W-1:0] cdb_tag;
    logic [RS_W-1:0]  cdb_rs_id;
    logic [WIDTH-1:0] cdb_value;
    logic             lsq_valid;
    logic [LSQ_W-1:0] lsq_id_out;
    logic [WIDTH-1:0] lsq_addr;
    logic [WIDTH-1:0] lsq_data;
    logic             br_valid;
    logic [ROB_W-1:0] br_tag;
    logic             br_taken;
    logic             state_dbg;

    // Handshakes: an op transfers on a posedge where tag_in!=0, exe_busy=0 and flush=0;
    // a CDB result transfers on a posedge where cdb_valid=1 and cdb_ready=1.
    // lsq_valid and br_valid are single-cycle pulses with no back-pressure.
    modport slave (
        input  flush, tag_in, rs_id_in, lsq_id_in, source_a, source_b, data_in, ctrl_in, cdb_ready,
        output exe_busy, cdb_valid, cdb_tag, cdb_rs_id, cdb_value,
               lsq_valid, lsq_id_out, lsq_addr, lsq_data, br_valid, br_tag, br_taken, state_dbg
    );

    modport master (
        output flush, tag_in, rs_id_in, lsq_id_in, source_a, source_b, data_in, ctrl_in, cdb_ready,
        input  exe_busy, cdb_valid, cdb_tag, cdb_rs_id, cdb_value,
               lsq_valid, lsq_id_out, lsq_addr, lsq_data, br_valid, br_tag, br_taken, state_dbg
    );
endinterface

// File: rtl/execute_unit.sv
// Integer execute stage: 1-cycle ALU, iterative shift-add MUL, LSQ address generation and branch resolution.
// ALU/MUL/JMP-link results leave on the CDB under a valid/ready handshake; exe_busy holds issue.
module execute_unit #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32,
    parameter int ROB_W     = 5,
    parameter int RS_W      = 4,
    parameter int LSQ_W     = 4
) (
    input logic           clk,
    input logic           reset,
    execute_unit_if.slave eu
);
    localparam int CW   = $clog2(MUL_STEPS);
    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [RS_W-1:0]  cdb_rs_id_q, cdb_rs_id_d;
    logic [WIDTH-1:0] cdb_value_q, cdb_value_d;
    logic             lsq_valid_q, lsq_valid_d;
    logic [LSQ_W-1:0] lsq_id_q, lsq_id_d;
    logic [WIDTH-1:0] lsq_addr_q, lsq_addr_d;
    logic [WIDTH-1:0] lsq_data_q, lsq_data_d;
    logic             br_valid_q, br_valid_d;
    logic [ROB_W-1:0] br_tag_q, br_tag_d;
    logic             br_taken_q, br_taken_d;
    logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
    logic [ROB_W-1:0] mul_tag_q, mul_tag_d;
    logic [RS_W-1:0]  mul_rs_q, mul_rs_d;

    logic [3:0]       aluop;
    logic             is_mem, is_br, is_jmp, is_mul;
    logic             accept, busy;
    logic             mul_last;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] alu_res;
    logic [SH_W-1:0]  shamt;
    logic             br_cond;
    logic             unused_regwrite;

    assign unused_regwrite = eu.ctrl_in[0];

    // Priority-ordered classification of the presented op
    assign aluop  = eu.ctrl_in[8:5];
    assign is_mem = eu.ctrl_in[4] | eu.ctrl_in[3];
    assign is_br  = !is_mem && eu.ctrl_in[2];
    assign is_jmp = !is_mem && !eu.ctrl_in[2] && eu.ctrl_in[1];
    assign is_mul = !is_mem && !eu.ctrl_in[2] && !eu.ctrl_in[1] && (aluop == 4'd10);

    assign busy     = (state_q == S_MUL) || (cdb_valid_q && !eu.cdb_ready);
    assign accept   = (eu.tag_in != '0) && !busy && !eu.flush;
    assign mul_last = (state_q == S_MUL) && (mul_cnt_q == CW'(MUL_STEPS - 1));
    assign mul_sum  = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
    assign shamt    = eu.source_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (aluop)
            4'd0:    alu_res = eu.source_a + eu.source_b;
            4'd1:    alu_res = eu.source_a - eu.source_b;
            4'd2:    alu_res = eu.source_a & eu.source_b;
            4'd3:    alu_res = eu.source_a | eu.source_b;
            4'd4:    alu_res = eu.source_a ^ eu.source_b;
            4'd5:    alu_res = WIDTH'($signed(eu.source_a) < $signed(eu.source_b));
            4'd6:    alu_res = WIDTH'(eu.source_a < eu.source_b);
            4'd7:    alu_res = eu.source_a << shamt;
            4'd8:    alu_res = eu.source_a >> shamt;
            4'd9:    alu_res = $unsigned($signed(eu.source_a) >>> shamt);
            4'd11:   alu_res = eu.source_b;
            4'd12:   alu_res = WIDTH'(eu.source_a == eu.source_b);
            4'd13:   alu_res = WIDTH'(eu.source_a != eu.source_b);
            4'd14:   alu_res = WIDTH'($signed(eu.source_a) < $signed(eu.source_b));
            4'd15:   alu_res = WIDTH'($signed(eu.source_a) >= $signed(eu.source_b));
            default: alu_res = '0;
        endcase
    end

    // Only the compare opcodes resolve a conditional branch
    assign br_cond = (aluop[3:2] == 2'b11) && alu_res[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_rs_id_q <= '0;
            cdb_value_q <= '0;
            lsq_valid_q <= 1'b0;
            lsq_id_q    <= '0;
            lsq_addr_q  <= '0;
            lsq_data_q  <= '0;
            br_valid_q  <= 1'b0;
            br_tag_q    <= '0;
            br_taken_q  <= 1'b0;
            mul_acc_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_cnt_q   <= '0;
            mul_tag_q   <= '0;
            mul_rs_q    <= '0;
        end else begin
            state_q     <= state_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_rs_id_q <= cdb_rs_id_d;
            cdb_value_q <= cdb_value_d;
            lsq_valid_q <= lsq_valid_d;
            lsq_id_q    <= lsq_id_d;
            lsq_addr_q  <= lsq_addr_d;
            lsq_data_q  <= lsq_data_d;
            br_valid_q  <= br_valid_d;
            br_tag_q    <= br_tag_d;
            br_taken_q  <= br_taken_d;
            mul_acc_q   <= mul_acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_cnt_q   <= mul_cnt_d;
            mul_tag_q   <= mul_tag_d;
            mul_rs_q    <= mul_rs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul) state_d = S_MUL;
            S_MUL:   if (mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (eu.flush) state_d = S_IDLE;
    end

    always_comb begin
        cdb_valid_d = cdb_valid_q && !eu.cdb_ready;
        cdb_tag_d   = cdb_tag_q;
        cdb_rs_id_d = cdb_rs_id_q;
        cdb_value_d = cdb_value_q;
        lsq_valid_d = 1'b0;
        lsq_id_d    = lsq_id_q;
        lsq_addr_d  = lsq_addr_q;
        lsq_data_d  = lsq_data_q;
        br_valid_d  = 1'b0;
        br_tag_d    = br_tag_q;
        br_taken_d  = br_taken_q;
        mul_acc_d   = mul_acc_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_cnt_d   = mul_cnt_q;
        mul_tag_d   = mul_tag_q;
        mul_rs_d    = mul_rs_q;

        if (state_q == S_MUL) begin
            mul_acc_d = mul_sum;
            mul_a_d   = mul_a_q << 1;
            mul_b_d   = mul_b_q >> 1;
            mul_cnt_d = mul_cnt_q + CW'(1);
            if (mul_last) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = mul_tag_q;
                cdb_rs_id_d = mul_rs_q;
                cdb_value_d = mul_sum;
            end
        end

        if (accept) begin
            if (is_mem) begin
                lsq_valid_d = 1'b1;
                lsq_id_d    = eu.lsq_id_in;
                lsq_addr_d  = eu.source_a + eu.source_b;
                lsq_data_d  = eu.data_in;
            end else if (is_br) begin
                br_valid_d = 1'b1;
                br_tag_d   = eu.tag_in;
                br_taken_d = br_cond;
            end else if (is_jmp) begin
                br_valid_d  = 1'b1;
                br_tag_d    = eu.tag_in;
                br_taken_d  = 1'b1;
                cdb_valid_d = 1'b1;
                cdb_tag_d   = eu.tag_in;
                cdb_rs_id_d = eu.rs_id_in;
                cdb_value_d = eu.source_a;
            end else if (is_mul) begin
                mul_acc_d = '0;
                mul_a_d   = eu.source_a;
                mul_b_d   = eu.source_b;
                mul_cnt_d = '0;
                mul_tag_d = eu.tag_in;
                mul_rs_d  = eu.rs_id_in;
            end else begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = eu.tag_in;
                cdb_rs_id_d = eu.rs_id_in;
                cdb_value_d = alu_res;
            end
        end

        // A result handed over in the flush cycle is still consumed; nothing new survives
        if (eu.flush) begin
            cdb_valid_d = 1'b0;
            lsq_valid_d = 1'b0;
            br_valid_d  = 1'b0;
        end
    end

    always_comb begin
        eu.exe_busy   = busy;
        eu.cdb_valid  = cdb_valid_q;
        eu.cdb_tag    = cdb_tag_q;
        eu.cdb_rs_id  = cdb_rs_id_q;
        eu.cdb_value  = cdb_value_q;
        eu.lsq_valid  = lsq_valid_q;
        eu.lsq_id_out = lsq_id_q;
        eu.lsq_addr   = lsq_addr_q;
        eu.lsq_data   = lsq_data_q;
        eu.br_valid   = br_valid_q;
        eu.br_tag     = br_tag_q;
        eu.br_taken   = br_taken_q;
        eu.state_dbg  = state_q;
    end
endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed scenarios, then random ops under random CDB back-pressure.
module tb_execute_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   last_xfer = 0;
  int   prev_xfer = 0;
  int   cdb_seen = 0;
  bit   rand_ready_en = 1'b0;

  logic [40:0] cdb_exp_q[$];
  logic [67:0] lsq_exp_q[$];
  logic [5:0]  br_exp_q[$];
  logic [40:0] cdb_e;
  logic [67:0] lsq_e;
  logic [5:0]  br_e;

  execute_unit_if #(.WIDTH(W), .ROB_W(5), .RS_W(4), .LSQ_W(4)) eu_if ();

  execute_unit #(.WIDTH(W), .MUL_STEPS(32), .ROB_W(5), .RS_W(4), .LSQ_W(4)) dut (
    .clk   (clk),
    .reset (rst),
    .eu    (eu_if)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] mk_ctrl(input logic [3:0] op, input logic mr, input logic mw,
                                         input logic cj, input logic uj);
    return {op, mr, mw, cj, uj, 1'b1};
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + ~b + 1;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb) ? 1 : 0;
      4'd6:  r = (a < b) ? 1 : 0;
      4'd7:  r = a << b[4:0];
      4'd8:  r = a >> b[4:0];
      4'd9:  r = sa >>> b[4:0];
      4'd10: r = a * b;
      4'd11: r = b;
      4'd12: r = (a == b) ? 1 : 0;
      4'd13: r = (a != b) ? 1 : 0;
      4'd14: r = (sa < sb) ? 1 : 0;
      default: r = (sa >= sb) ? 1 : 0;
    endcase
    return r;
  endfunction

  // driver: hold the op until the unit takes it, then queue what it must produce
  task automatic drive_op(input logic [4:0] tag, input logic [3:0] rs, input logic [3:0] lsq,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] d,
                          input logic [8:0] ctrl, input bit push);
    int waited = 0;
    eu_if.tag_in = tag;
    eu_if.rs_id_in = rs;
    eu_if.lsq_id_in = lsq;
    eu_if.source_a = a;
    eu_if.source_b = b;
    eu_if.data_in = d;
    eu_if.ctrl_in = ctrl;
    @(negedge clk);
    while (eu_if.exe_busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (eu_if.exe_busy) begin
      check_eq("issue_timeout", 1, 0);
      @(posedge clk);
      #1 eu_if.tag_in = '0;
      return;
    end
    if (push) begin
      if (ctrl[4] || ctrl[3]) lsq_exp_q.push_back({lsq, a + b, d});
      else if (ctrl[2]) br_exp_q.push_back({tag, (ctrl[8:7] == 2'b11) ? ref_alu(ctrl[8:5], a, b) == 1 : 1'b0});
      else if (ctrl[1]) begin
        br_exp_q.push_back({tag, 1'b1});
        cdb_exp_q.push_back({tag, rs, a});
      end else cdb_exp_q.push_back({tag, rs, ref_alu(ctrl[8:5], a, b)});
    end
    @(posedge clk);
    #1 eu_if.tag_in = '0;
  endtask

  // scoreboard: pop on every CDB transfer and every LSQ/branch pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (eu_if.cdb_valid) cdb_seen++;
      if (eu_if.cdb_valid && eu_if.cdb_ready) begin
        if (cdb_exp_q.size() == 0) check_eq("cdb_unexpected", {eu_if.cdb_tag, eu_if.cdb_value}, 0);
        else begin
          cdb_e = cdb_exp_q.pop_front();
          check_eq("cdb", {eu_if.cdb_tag, eu_if.cdb_rs_id, eu_if.cdb_value}, cdb_e);
        end
        prev_xfer = last_xfer;
        last_xfer = cyc;
      end
      if (eu_if.lsq_valid) begin
        if (lsq_exp_q.size() == 0) check_eq("lsq_unexpected", eu_if.lsq_addr, 0);
        else begin
          lsq_e = lsq_exp_q.pop_front();
          check_eq("lsq", {eu_if.lsq_id_out, eu_if.lsq_addr, eu_if.lsq_data}, lsq_e);
        end
      end
      if (eu_if.br_valid) begin
        if (br_exp_q.size() == 0) check_eq("br_unexpected", eu_if.br_tag, 0);
        else begin
          br_e = br_exp_q.pop_front();
          check_eq("br", {eu_if.br_tag, eu_if.br_taken}, br_e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 if (rand_ready_en) eu_if.cdb_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n, seen0, kind;
    logic [4:0] tag;
    logic [3:0] rs, lq, op;
    logic [W-1:0] a, b, d;
    logic [8:0] ctrl;
    logic mr, mw;

    eu_if.flush = 0; eu_if.tag_in = 0; eu_if.rs_id_in = 0; eu_if.lsq_id_in = 0;
    eu_if.source_a = 0; eu_if.source_b = 0; eu_if.data_in = 0; eu_if.ctrl_in = 0;
    eu_if.cdb_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset state
    @(negedge clk);
    #1;
    check_eq("rst_valids", {eu_if.cdb_valid, eu_if.lsq_valid, eu_if.br_valid, eu_if.exe_busy, eu_if.state_dbg}, 0);
    check_eq("rst_cdb", {eu_if.cdb_tag, eu_if.cdb_rs_id, eu_if.cdb_value}, 0);
    @(posedge clk);
    #1;

    // back-to-back ADDs, no bubble
    drive_op(5'd3, 4'd1, 4'd0, 32'd5, 32'd7, 32'd0, mk_ctrl(4'd0, 0, 0, 0, 0), 1);
    drive_op(5'd4, 4'd2, 4'd0, 32'd20, 32'd22, 32'd0, mk_ctrl(4'd0, 0, 0, 0, 0), 1);
    @(negedge clk);
    #1;
    check_eq("add_no_bubble", last_xfer - prev_xfer, 1);
    check_eq("add2_tag", eu_if.cdb_tag, 4);
    @(posedge clk);
    #1;

    // SUB held under back-pressure; a presented op must not be taken
    eu_if.cdb_ready = 0;
    drive_op(5'd2, 4'd3, 4'd0, 32'd1, 32'd2, 32'd0, mk_ctrl(4'd1, 0, 0, 0, 0), 1);
    eu_if.tag_in = 5'd6; eu_if.rs_id_in = 4'd4; eu_if.source_a = 32'd1; eu_if.source_b = 32'd1;
    eu_if.ctrl_in = mk_ctrl(4'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("hold_value", {eu_if.cdb_valid, eu_if.cdb_tag, eu_if.cdb_value}, {1'b1, 5'd2, 32'hFFFF_FFFF});
      check_eq("hold_busy", eu_if.exe_busy, 1);
    end
    @(posedge clk);
    #1 eu_if.cdb_ready = 1;
    @(negedge clk);
    check_eq("release_busy", eu_if.exe_busy, 0);
    cdb_exp_q.push_back({5'd6, 4'd4, 32'd2});
    @(posedge clk);
    #1 eu_if.tag_in = 0;

    // MUL latency and low word
    drive_op(5'd5, 4'd5, 4'd0, 32'h0001_0000, 32'h0001_0001, 32'd0, mk_ctrl(4'd10, 0, 0, 0, 0), 1);
    n = 0;
    @(negedge clk);
    #1;
    while (eu_if.exe_busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq("mul_busy_cycles", n, 32);
    check_eq("mul_result", {eu_if.cdb_valid, eu_if.cdb_tag, eu_if.cdb_value}, {1'b1, 5'd5, 32'h0001_0000});
    @(posedge clk);
    #1;

    // store address generation, then BEQ
    drive_op(5'd7, 4'd6, 4'd2, 32'h100, 32'd8, 32'hAB, mk_ctrl(4'd0, 0, 1, 0, 0), 1);
    @(negedge clk);
    #1;
    check_eq("st_pulse", {eu_if.lsq_valid, eu_if.lsq_id_out, eu_if.lsq_addr, eu_if.lsq_data, eu_if.cdb_valid},
             {1'b1, 4'd2, 32'h108, 32'hAB, 1'b0});
    @(negedge clk);
    #1;
    check_eq("st_one_cycle", eu_if.lsq_valid, 0);
    @(posedge clk);
    #1;
    drive_op(5'd8, 4'd7, 4'd0, 32'd9, 32'd9, 32'd0, mk_ctrl(4'd12, 0, 0, 1, 0), 1);
    @(negedge clk);
    #1;
    check_eq("beq", {eu_if.br_valid, eu_if.br_tag, eu_if.br_taken, eu_if.cdb_valid}, {1'b1, 5'd8, 1'b1, 1'b0});
    @(posedge clk);
    #1;

    // flush in cycle 15 of a MUL with a new op presented
    drive_op(5'd9, 4'd1, 4'd0, 32'd3, 32'd4, 32'd0, mk_ctrl(4'd10, 0, 0, 0, 0), 0);
    seen0 = cdb_seen;
    repeat (14) @(posedge clk);
    #1;
    eu_if.flush = 1; eu_if.tag_in = 5'd10; eu_if.ctrl_in = mk_ctrl(4'd0, 0, 0, 0, 0);
    @(posedge clk);
    #1 eu_if.flush = 0; eu_if.tag_in = 0;
    @(negedge clk);
    #1;
    check_eq("flush_state", {eu_if.state_dbg, eu_if.exe_busy, eu_if.cdb_valid}, 0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("flush_no_cdb", cdb_seen - seen0, 0);

    // flush while idle drops the presented op
    eu_if.flush = 1; eu_if.tag_in = 5'd11; eu_if.ctrl_in = mk_ctrl(4'd0, 0, 0, 0, 1);
    @(posedge clk);
    #1 eu_if.flush = 0; eu_if.tag_in = 0;
    @(negedge clk);
    #1;
    check_eq("idle_flush", {eu_if.cdb_valid, eu_if.br_valid}, 0);
    @(posedge clk);
    #1;

    // asynchronous reset in cycle 10 of a MUL
    drive_op(5'd12, 4'd2, 4'd0, 32'd6, 32'd7, 32'd0, mk_ctrl(4'd10, 0, 0, 0, 0), 0);
    seen0 = cdb_seen;
    repeat (9) @(posedge clk);
    #1 rst = 1;
    #1;
    check_eq("rst_mul_out", {eu_if.cdb_valid, eu_if.lsq_valid, eu_if.br_valid, eu_if.state_dbg, eu_if.exe_busy, eu_if.cdb_value}, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    #1;
    check_eq("rst_mul_busy", eu_if.exe_busy, 0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("rst_mul_no_cdb", cdb_seen - seen0, 0);

    // random mix under random back-pressure
    rand_ready_en = 1;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 7);
      tag = 5'($urandom_range(1, 31));
      rs = 4'($urandom_range(0, 15));
      lq = 4'($urandom_range(0, 15));
      a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
      b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
      if ($urandom_range(0, 4) == 0) b = a;
      d = $urandom;
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd10) op = op + 4'd1;
      mr = 1'($urandom_range(0, 1));
      mw = mr ? 1'($urandom_range(0, 1)) : 1'b1;
      case (kind)
        3: ctrl = mk_ctrl(op, mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        4: ctrl = mk_ctrl(4'($urandom_range(12, 15)), 0, 0, 1, 1'($urandom_range(0, 1)));
        5: ctrl = mk_ctrl(op, 0, 0, 0, 1);
        6: ctrl = mk_ctrl(4'd10, 0, 0, 0, 0);
        default: ctrl = mk_ctrl(op, 0, 0, 0, 0);
      endcase
      drive_op(tag, rs, lq, a, b, d, ctrl, 1);
    end
    rand_ready_en = 0;
    #1 eu_if.cdb_ready = 1;
    repeat (50) @(posedge clk);
    #1;
    check_eq("cdb_q_left", cdb_exp_q.size(), 0);
    check_eq("lsq_q_left", lsq_exp_q.size(), 0);
    check_eq("br_q_left", br_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
